serial_adder: RTL and testbench

Parametrised multi-cycle ripple adder: accepts two WIDTH-bit operands and a carry-in over a valid/ready handshake, adds them DIGIT bits per clock (least-significant digit first) through a registered carry, and presents sum and carry-out over a second valid/ready handshake. It is the area-reduced, sequential successor to the single-bit half adder in the arithmetic library. It is used where wide additions are infrequent and adder area matters more than latency.

---
 rtl/serial_adder.sv | 113 +++++++++++
 tb/tb_serial_adder.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder: multi-cycle ripple adder, DIGIT bits per clock, LSB digit first.
// Operands arrive over an in_valid/in_ready handshake; the sum and carry-out
// leave over an out_valid/out_ready handshake.
// Optional feature macro: SERIAL_ADDER_SUB_EN adds the sub port (a - b).
module serial_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             busy
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int KW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [KW-1:0] KLAST = KW'(NDIG - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [KW-1:0]    k_q;
    logic             carry_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] s_q;
    logic             co_q;
    logic [DIGIT:0]   dsum_d;
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;

    // Operand conditioning at acceptance: subtraction is a + ~b + 1.
`ifdef SERIAL_ADDER_SUB_EN
    assign b_eff = sub ? ~b : b;
    assign c_eff = sub ? 1'b1 : ci;
`else
    assign b_eff = b;
    assign c_eff = ci;
`endif

    // One digit of the ripple: current digits of A and B plus the stored carry.
    always_comb begin
        dsum_d = {1'b0, a_q[k_q*DIGIT +: DIGIT]}
               + {1'b0, b_q[k_q*DIGIT +: DIGIT]}
               + {{DIGIT{1'b0}}, carry_q};
    end

    // Next-state logic for the IDLE -> RUN -> DONE sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid)       state_d = ST_RUN;
            ST_RUN:  if (k_q == KLAST)   state_d = ST_DONE;
            ST_DONE: if (out_ready)      state_d = ST_IDLE;
            default:                     state_d = ST_IDLE;
        endcase
    end

    // State register; reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Datapath: latch operands in IDLE, write one sum digit per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q     <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            co_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b_eff;
                        carry_q <= c_eff;
                        k_q     <= '0;
                    end
                end
                ST_RUN: begin
                    s_q[k_q*DIGIT +: DIGIT] <= dsum_d[DIGIT-1:0];
                    carry_q                 <= dsum_d[DIGIT];
                    if (k_q == KLAST) co_q <= dsum_d[DIGIT];
                    else              k_q  <= k_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign s         = s_q;
    assign co        = co_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder against a plain-arithmetic model.
// Build with SERIAL_ADDER_SUB_EN defined to also exercise subtraction.
module tb_serial_adder;

    localparam int WIDTH = 16;
    localparam int DIGIT = 4;
    localparam int NDIG  = WIDTH / DIGIT;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             ci = 1'b0;
    logic             sub = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] s;
    logic             co;
    logic             busy;

    int total = 0;
    int bad   = 0;

    serial_adder #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .ci(ci),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .co(co), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference: {co,s} as an unsigned (WIDTH+1)-bit sum or difference.
    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y,
                                             input logic c, input logic sb);
        int unsigned r;
`ifdef SERIAL_ADDER_SUB_EN
        if (sb) r = int'(x) + (int'(2**WIDTH) - 1 - int'(y)) + 1;
        else    r = int'(x) + int'(y) + int'(c);
`else
        r = int'(x) + int'(y) + int'(c);
`endif
        return r[WIDTH:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one transaction; reports result, latency and whether it timed out.
    task automatic run_op(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                          input logic xc, input logic xs,
                          output logic [WIDTH-1:0] rs, output logic rco,
                          output int lat, output bit tmo);
        a = xa; b = xb; ci = xc; sub = xs;
        in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        lat = 0; tmo = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (out_valid) begin lat = i; tmo = 1'b0; break; end
        end
        rs = s; rco = co;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [WIDTH-1:0] rs; logic rco; int lat; bit tmo;
        run_op(16'hA5A5, 16'h1234, 1'b1, 1'b0, rs, rco, lat, tmo);
        a = 16'h8000; b = 16'h8000; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < NDIG; i++) tick();
        #2 rst_n = 1'b0;
        #1;
        total++; if (s !== '0) begin bad++; $display("FAIL reset_s got=%h exp=0000", s); end
        total++; if (co !== 1'b0) begin bad++; $display("FAIL reset_co got=%b exp=0", co); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        tick();
        rst_n = 1'b1;
        tick();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_directed();
        logic [WIDTH-1:0] va [3] = '{16'h1234, 16'hFFFF, 16'hFFFF};
        logic [WIDTH-1:0] vb [3] = '{16'h1111, 16'h0000, 16'hFFFF};
        logic             vc [3] = '{1'b0, 1'b1, 1'b1};
        logic [WIDTH:0]   ve [3] = '{17'h02345, 17'h10000, 17'h1FFFF};
        logic [WIDTH-1:0] rs; logic rco; int lat; bit tmo;
        for (int i = 0; i < 3; i++) begin
            run_op(va[i], vb[i], vc[i], 1'b0, rs, rco, lat, tmo);
            total++; if (tmo) begin bad++; $display("FAIL dir_timeout idx=%0d no out_valid", i); end
            total++; if (lat != NDIG) begin bad++; $display("FAIL dir_latency idx=%0d got=%0d exp=%0d", i, lat, NDIG); end
            total++; if ({rco, rs} !== ve[i]) begin
                bad++; $display("FAIL dir_sum idx=%0d got=%b_%h exp=%h", i, rco, rs, ve[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] xa, xb, rs; logic xc, xs, rco; int lat; bit tmo;
        logic [WIDTH:0] e;
        for (int i = 0; i < 40; i++) begin
            xa = WIDTH'($urandom); xb = WIDTH'($urandom); xc = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
            xs = 1'($urandom);
`else
            xs = 1'b0;
`endif
            e = model(xa, xb, xc, xs);
            run_op(xa, xb, xc, xs, rs, rco, lat, tmo);
            total++; if (tmo || {rco, rs} !== e) begin
                bad++; $display("FAIL rand_sum a=%h b=%h ci=%b sub=%b got=%b_%h exp=%h tmo=%0d",
                                xa, xb, xc, xs, rco, rs, e, tmo);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] hs; logic hco; logic [WIDTH:0] e;
        bit seen = 0;
        a = 16'h4321; b = 16'h0F0F; ci = 1'b1; sub = 1'b0;
        in_valid = 1'b1; out_ready = 1'b0;
        tick();
        for (int i = 0; i < 40; i++) begin
            if (out_valid) begin seen = 1; break; end
            a = WIDTH'($urandom); b = WIDTH'($urandom);
            tick();
        end
        total++; if (!seen) begin bad++; $display("FAIL bp_timeout no out_valid"); end
        hs = s; hco = co;
        total++; if ({hco, hs} !== model(16'h4321, 16'h0F0F, 1'b1, 1'b0)) begin
            bad++; $display("FAIL bp_result got=%b_%h exp=%h", hco, hs, model(16'h4321, 16'h0F0F, 1'b1, 1'b0));
        end
        for (int i = 0; i < 5; i++) begin
            a = WIDTH'($urandom); b = WIDTH'($urandom);
            tick();
            total++; if (s !== hs || co !== hco || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                bad++; $display("FAIL bp_hold cyc=%0d s=%h/%h co=%b/%b in_ready=%b out_valid=%b",
                                i, s, hs, co, hco, in_ready, out_valid);
            end
        end
        a = 16'h00FF; b = 16'h0001; ci = 1'b0;
        e = model(16'h00FF, 16'h0001, 1'b0, 1'b0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL bp_release in_ready=%b exp=1 out_valid=%b exp=0", in_ready, out_valid);
        end
        tick();
        in_valid = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL bp_next_accept busy=%b exp=1", busy); end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid) begin seen = 1; break; end
        end
        total++; if (!seen || {co, s} !== e) begin
            bad++; $display("FAIL bp_next_sum got=%b_%h exp=%h seen=%0d", co, s, e, seen);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        logic [WIDTH-1:0] rs; logic rco; int lat; bit tmo;
        bit pulse = 0;
        a = 16'h7777; b = 16'h9999; ci = 1'b1; sub = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        total++; if (s !== '0 || busy !== 1'b0) begin
            bad++; $display("FAIL midrun_reset s=%h exp=0000 busy=%b exp=0", s, busy);
        end
        for (int i = 0; i < 3; i++) begin tick(); if (out_valid) pulse = 1; end
        rst_n = 1'b1;
        for (int i = 0; i < NDIG + 2; i++) begin tick(); if (out_valid) pulse = 1; end
        total++; if (pulse) begin bad++; $display("FAIL midrun_pulse got=1 exp=0"); end
        run_op(16'h0001, 16'h0001, 1'b0, 1'b0, rs, rco, lat, tmo);
        total++; if (tmo || {rco, rs} !== 17'h00002) begin
            bad++; $display("FAIL midrun_fresh got=%b_%h exp=00002 tmo=%0d", rco, rs, tmo);
        end
    endtask

    task automatic test_back_to_back();
        int acc [$];
        int nval = 0;
        logic [WIDTH:0] e = model(16'hBEEF, 16'h1357, 1'b1, 1'b0);
        a = 16'hBEEF; b = 16'h1357; ci = 1'b1; sub = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 4 * (NDIG + 2); i++) begin
            if (in_ready) acc.push_back(i);
            if (out_valid) begin
                nval++;
                total++; if ({co, s} !== e) begin
                    bad++; $display("FAIL b2b_sum cyc=%0d got=%b_%h exp=%h", i, co, s, e);
                end
            end
            tick();
        end
        in_valid = 1'b0;
        total++; if (acc.size() < 3 || nval < 3) begin
            bad++; $display("FAIL b2b_count accepts=%0d results=%0d exp>=3", acc.size(), nval);
        end else begin
            for (int i = 1; i < acc.size(); i++) begin
                total++; if (acc[i] - acc[i-1] != NDIG + 2) begin
                    bad++; $display("FAIL b2b_period got=%0d exp=%0d", acc[i] - acc[i-1], NDIG + 2);
                end
            end
        end
        for (int i = 0; i < NDIG + 3; i++) tick();
        out_ready = 1'b0;
    endtask

`ifdef SERIAL_ADDER_SUB_EN
    task automatic test_sub();
        logic [WIDTH-1:0] rs; logic rco; int lat; bit tmo;
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1, rs, rco, lat, tmo);
        total++; if (tmo || {rco, rs} !== 17'h0FFFE) begin
            bad++; $display("FAIL sub_neg got=%b_%h exp=0FFFE", rco, rs);
        end
        run_op(16'h0007, 16'h0005, 1'b0, 1'b1, rs, rco, lat, tmo);
        total++; if (tmo || {rco, rs} !== 17'h10002) begin
            bad++; $display("FAIL sub_pos got=%b_%h exp=10002", rco, rs);
        end
        run_op(16'h1234, 16'h1234, 1'b0, 1'b1, rs, rco, lat, tmo);
        total++; if (tmo || {rco, rs} !== 17'h10000) begin
            bad++; $display("FAIL sub_eq got=%b_%h exp=10000", rco, rs);
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        #23 rst_n = 1'b1;
        tick();
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
`ifdef SERIAL_ADDER_SUB_EN
        test_sub();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
